// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser host sequencer: FSM states,
// command byte defaults and analyser config-byte field positions.
package la_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CFG,
    ST_GET_LH,
    ST_GET_LL,
    ST_ARM,
    ST_CAPTURE,
    ST_STOP,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } la_state_e;

  localparam logic [7:0] HDR_BYTE_DEF   = 8'hA5;
  localparam logic [7:0] ABORT_BYTE_DEF = 8'h5A;

  localparam int unsigned CFG_RATE_MSB = 6;
  localparam int unsigned CFG_RATE_LSB = 4;
  localparam int unsigned CFG_EDGE     = 3;
  localparam int unsigned CFG_FREERUN  = 0;

  // States in which an abort byte from the host is honoured.
  function automatic logic abortable(input la_state_e st);
    return st inside {ST_GET_CFG, ST_GET_LH, ST_GET_LL, ST_ARM, ST_CAPTURE};
  endfunction

endpackage

// File: rtl/la_cmd_parser.sv
// Collects CFG / LEN_H / LEN_L bytes of a command frame while the top FSM
// walks the GET_* states, and judges the frame on its last byte.
module la_cmd_parser
  import la_pkg::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter logic [7:0]  ABORT_BYTE = ABORT_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  la_state_e        state,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [7:0]       cfg,
  output logic [LEN_W-1:0] len,
  output logic             frame_ok,
  output logic             cmd_err
);

  logic [7:0] cfg_q, cfg_d;
  logic [7:0] len_h_q, len_h_d;
  logic [7:0] len_l_q, len_l_d;
  logic       cmd_err_q, cmd_err_d;
  logic       rx_take;

  always_comb begin
    cfg_d     = cfg_q;
    len_h_d   = len_h_q;
    len_l_d   = len_l_q;
    cmd_err_d = 1'b0;
    frame_ok  = 1'b0;
    // An abort byte is never taken as frame payload.
    rx_take   = rx_valid && (rx_data != ABORT_BYTE);
    case (state)
      ST_GET_CFG: if (rx_take) cfg_d = rx_data;
      ST_GET_LH:  if (rx_take) len_h_d = rx_data;
      ST_GET_LL: begin
        if (rx_take) begin
          len_l_d   = rx_data;
          frame_ok  = (cfg_q != 8'h00) && ({len_h_q, rx_data} != 16'h0000);
          cmd_err_d = !frame_ok;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      len_h_q   <= '0;
      len_l_q   <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      len_h_q   <= len_h_d;
      len_l_q   <= len_l_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign cfg     = cfg_q;
  assign len     = LEN_W'({len_h_q, len_l_q});
  assign cmd_err = cmd_err_q;

endmodule

// File: rtl/la_capture_ctrl.sv
// Host-side sequencer: parses a command frame, arms the analyser, counts
// captured bytes, stops it, then drains the capture FIFO to UART TX.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF,
  parameter logic [7:0]  ABORT_BYTE = ABORT_BYTE_DEF,
  parameter int unsigned SETTLE     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       cfg_valid,
  output logic [7:0] cfg_data,
  input  logic       cap_wen,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rd_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  localparam int unsigned SW = $clog2(SETTLE + 1);

  la_state_e        state_q, state_d;
  logic [LEN_W-1:0] cap_cnt_q, cap_cnt_d;
  logic [LEN_W-1:0] lim_q, lim_d;
  logic [LEN_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [7:0]       cfg_data_q, cfg_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [7:0]       skid_data_q, skid_data_d;
  logic             rd_pend_q, rd_pend_d;

  logic [7:0]       p_cfg;
  logic [LEN_W-1:0] p_len;
  logic             p_ok;
  logic             rx_abort;
  logic             accept;
  logic [1:0]       occ_after;
  logic [LEN_W-1:0] cap_inc;
  logic [LEN_W-1:0] target;

  la_cmd_parser #(
    .LEN_W      (LEN_W),
    .ABORT_BYTE (ABORT_BYTE)
  ) u_parser (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_q),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .cfg      (p_cfg),
    .len      (p_len),
    .frame_ok (p_ok),
    .cmd_err  (cmd_err)
  );

  always_comb begin
    state_d     = state_q;
    cap_cnt_d   = cap_cnt_q;
    lim_d       = lim_q;
    sent_cnt_d  = sent_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    settle_d    = '0;
    cfg_valid_d = 1'b0;
    cfg_data_d  = cfg_data_q;
    fifo_rd_en  = 1'b0;

    rx_abort  = rx_valid && (rx_data == ABORT_BYTE) && abortable(state_q);
    cap_inc   = (cap_wen && (cap_cnt_q != '1)) ? cap_cnt_q + LEN_W'(1) : cap_cnt_q;
    target    = (cap_cnt_q < lim_q) ? cap_cnt_q : lim_q;
    accept    = tx_valid_q && tx_ready;
    occ_after = 2'(tx_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q) - 2'(accept);

    case (state_q)
      ST_IDLE: begin
        cap_cnt_d  = '0;
        sent_cnt_d = '0;
        rd_cnt_d   = '0;
        if (rx_valid && (rx_data == HDR_BYTE)) state_d = ST_GET_CFG;
      end
      ST_GET_CFG: if (rx_valid) state_d = ST_GET_LH;
      ST_GET_LH:  if (rx_valid) state_d = ST_GET_LL;
      ST_GET_LL:  if (rx_valid) state_d = p_ok ? ST_ARM : ST_IDLE;
      ST_ARM: begin
        cap_cnt_d  = '0;
        sent_cnt_d = '0;
        rd_cnt_d   = '0;
        lim_d      = p_len;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cap_cnt_d = cap_inc;
        if (cap_inc >= lim_q) state_d = ST_STOP;
      end
      ST_STOP: begin
        cap_cnt_d = cap_inc;
        settle_d  = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // One more read only if its byte is sure to find room when it lands.
        fifo_rd_en = !fifo_empty && (rd_cnt_q < target) && (occ_after <= 2'd1);
        rd_cnt_d   = rd_cnt_q + LEN_W'(fifo_rd_en);
        sent_cnt_d = sent_cnt_q + LEN_W'(accept);
        if (sent_cnt_d == target) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort drains whatever was captured: lift the limit so target = cap_cnt.
    if (rx_abort) begin
      state_d = ST_STOP;
      lim_d   = '1;
    end

    if (state_d == ST_ARM) begin
      cfg_valid_d = 1'b1;
      cfg_data_d  = p_cfg;
    end else if ((state_d == ST_STOP) && (state_q != ST_STOP)) begin
      cfg_valid_d = 1'b1;
      cfg_data_d  = '0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);

    rd_pend_d    = fifo_rd_en && (state_q == ST_DRAIN);
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    // Two-entry hand-off (tx reg + skid) so back-to-back reads give 1 byte/clk.
    if (!tx_valid_q || accept) begin
      if (skid_valid_q) begin
        tx_valid_d   = 1'b1;
        tx_data_d    = skid_data_q;
        skid_valid_d = rd_pend_q;
        if (rd_pend_q) skid_data_d = fifo_rd_data;
      end else if (rd_pend_q) begin
        tx_valid_d = 1'b1;
        tx_data_d  = fifo_rd_data;
      end else begin
        tx_valid_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = fifo_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cap_cnt_q    <= '0;
      lim_q        <= '0;
      sent_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      settle_q     <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_cnt_q    <= cap_cnt_d;
      lim_q        <= lim_d;
      sent_cnt_q   <= sent_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      settle_q     <= settle_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_data_q   <= cfg_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_data  = cfg_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Scoreboard bench for la_capture_ctrl with a behavioural capture FIFO and
// a randomly throttled UART TX sink.
module tb_la_capture_ctrl;
  import la_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cap_wen = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       cmd_err;

  la_capture_ctrl #(
    .LEN_W      (16),
    .HDR_BYTE   (8'hA5),
    .ABORT_BYTE (8'h5A),
    .SETTLE     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cap_wen      (cap_wen),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] cfg_exp[$];
  logic [7:0] fifo_m[$];
  logic [7:0] cap_byte = '0;
  int         ready_pct = 100;
  int         tx_sent = 0;
  int         done_seen = 0;
  int         err_seen = 0;
  int         underflow = 0;
  logic       held = 1'b0;
  logic [7:0] held_data = '0;

  // Capture FIFO model: analyser writes on cap_wen, read data valid 1 cycle after rd_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_m.delete();
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        if (fifo_m.size() > 0) fifo_rd_data <= fifo_m.pop_front();
        else underflow++;
      end
      if (cap_wen) fifo_m.push_back(cap_byte);
      fifo_empty <= (fifo_m.size() == 0);
    end
  end

  // TX sink: choose ready, score handshakes, and check hold while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(held_data));
      end
      held = 1'b0;
      tx_ready = ($urandom_range(0, 99) < ready_pct);
      if (tx_valid) begin
        if (tx_ready) begin
          tx_sent++;
          if (exp_q.size() == 0) chk("tx_extra", 32'(exp_q.size()), 32'd1);
          else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end else begin
          held = 1'b1;
          held_data = tx_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_seen++;
      if (cmd_err) err_seen++;
      if (cfg_valid) begin
        if (cfg_exp.size() == 0) chk("cfg_extra", 32'(cfg_exp.size()), 32'd1);
        else chk("cfg_data", 32'(cfg_data), 32'(cfg_exp.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] lh, input logic [7:0] ll);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(lh);
    send_byte(ll);
  endtask

  // n back-to-back captured bytes; the first n_exp are expected on TX.
  task automatic capture(input int n, input int n_exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_wen  = 1'b1;
      cap_byte = 8'($urandom_range(0, 255));
      if (i < n_exp) exp_q.push_back(cap_byte);
    end
    @(negedge clk);
    cap_wen = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_seen;
    for (int i = 0; i < budget && done_seen == start; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("done_pulse", 32'(done_seen), 32'(start + 1));
  endtask

  task automatic post_checks();
    @(negedge clk);
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    chk("cfg_left", 32'(cfg_exp.size()), 32'd0);
    chk("fifo_left", 32'(fifo_m.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_cfg_valid"}, 32'(cfg_valid), 32'd0);
    chk({tag, "_cfg_data"}, 32'(cfg_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
  endtask

  initial begin
    logic [7:0] cfg_a;
    int base;
    cfg_a = 8'((3 << CFG_RATE_LSB) | (1 << CFG_EDGE) | (0 << CFG_FREERUN));

    #2 rst_n = 1'b0;
    #1 reset_checks("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic run: 8 bytes, full TX rate.
    cfg_exp.push_back(cfg_a);
    cfg_exp.push_back(8'h00);
    base = tx_sent;
    send_frame(cfg_a, 8'h00, 8'h08);
    capture(8, 8);
    wait_done(2000);
    chk("t1_sent", 32'(tx_sent - base), 32'd8);
    post_checks();

    // Rejected frames: zero config, then zero length.
    send_frame(8'h00, 8'h00, 8'h04);
    repeat (3) @(negedge clk);
    chk("t2_err_cfg0", 32'(err_seen), 32'd1);
    chk("t2_busy_a", 32'(busy), 32'd0);
    send_frame(cfg_a, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("t2_err_len0", 32'(err_seen), 32'd2);
    chk("t2_busy_b", 32'(busy), 32'd0);

    // Abort mid-capture: drain exactly what was captured.
    cfg_exp.push_back(8'h11);
    cfg_exp.push_back(8'h00);
    base = tx_sent;
    send_frame(8'h11, 8'h01, 8'h00);
    capture(20, 20);
    send_byte(8'h5A);
    wait_done(2000);
    chk("t3_sent", 32'(tx_sent - base), 32'd20);
    post_checks();

    // Late writes during settle are flushed, not sent.
    cfg_exp.push_back(cfg_a);
    cfg_exp.push_back(8'h00);
    base = tx_sent;
    send_frame(cfg_a, 8'h00, 8'h04);
    capture(6, 4);
    wait_done(2000);
    chk("t4_sent", 32'(tx_sent - base), 32'd4);
    post_checks();

    // Throttled TX.
    ready_pct = 30;
    cfg_exp.push_back(cfg_a);
    cfg_exp.push_back(8'h00);
    base = tx_sent;
    send_frame(cfg_a, 8'h00, 8'h10);
    capture(16, 16);
    wait_done(4000);
    chk("t5_sent", 32'(tx_sent - base), 32'd16);
    post_checks();

    // Reset in the middle of draining, then a clean run.
    cfg_exp.push_back(cfg_a);
    cfg_exp.push_back(8'h00);
    base = tx_sent;
    send_frame(cfg_a, 8'h00, 8'h10);
    capture(16, 16);
    for (int i = 0; i < 1000 && (tx_sent - base) < 3; i++) @(negedge clk);
    chk("t6_in_drain", 32'((tx_sent - base) >= 3), 32'd1);
    #3 rst_n = 1'b0;
    #1 reset_checks("t6_rst");
    exp_q.delete();
    cfg_exp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_pct = 100;
    cfg_exp.push_back(cfg_a);
    cfg_exp.push_back(8'h00);
    base = tx_sent;
    send_frame(cfg_a, 8'h00, 8'h05);
    capture(5, 5);
    wait_done(2000);
    chk("t6_sent", 32'(tx_sent - base), 32'd5);
    post_checks();

    chk("fifo_underflow", 32'(underflow), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
